// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit add/subtract, split into STAGES ripple segments of SEG bits.
// Latency: a beat accepted at edge N is on the outputs after edge N+STAGES-1.
// Backpressure: global stall. in_ready = out_ready | ~out_valid, and all stages hold together.
//
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   in_valid/in_ready             input handshake
//   in_a, in_b, in_cin, in_sub    operands. sub=0: A+B+cin. sub=1: A-B-borrow(cin)
//   in_tag                        user tag, carried unchanged with the beat
//   out_valid/out_ready           output handshake
//   out_sum, out_cout, out_ovf    result, carry out of MSB (sub: 1 = no borrow), signed overflow
//   out_tag                       tag of the presented result
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // Per-stage registers. r_sum[k] holds valid result bits [SEG*(k+1)-1:0].
  // r_a/r_b carry the operands forward so later stages can take their upper segments.
  logic             r_vld [STAGES];
  logic [WIDTH-1:0] r_sum [STAGES];
  logic             r_c   [STAGES];
  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic [TAG_W-1:0] r_tag [STAGES];
  logic             r_cmsb;           // carry into the MSB, captured by the last stage

  // Stage inputs: stage 0 reads the conditioned operands, stage k reads stage k-1.
  logic             w_src_vld [STAGES];
  logic [WIDTH-1:0] w_src_sum [STAGES];
  logic             w_src_c   [STAGES];
  logic [WIDTH-1:0] w_src_a   [STAGES];
  logic [WIDTH-1:0] w_src_b   [STAGES];
  logic [TAG_W-1:0] w_src_tag [STAGES];

  logic [SEG:0]     w_seg     [STAGES];  // {segment carry out, segment sum}
  logic [WIDTH-1:0] w_nxt_sum [STAGES];
  logic [WIDTH-1:0] w_b_eff;
  logic             w_c_eff;
  logic             w_cmsb;
  logic             w_advance;

  // Subtraction is A + ~B + ~borrow, so the adder itself never changes.
  always_comb begin
    w_b_eff = in_sub ? ~in_b : in_b;
    w_c_eff = in_sub ? ~in_cin : in_cin;

    w_src_vld[0] = in_valid;
    w_src_sum[0] = '0;
    w_src_c[0]   = w_c_eff;
    w_src_a[0]   = in_a;
    w_src_b[0]   = w_b_eff;
    w_src_tag[0] = in_tag;
    for (int k = 1; k < STAGES; k++) begin
      w_src_vld[k] = r_vld[k-1];
      w_src_sum[k] = r_sum[k-1];
      w_src_c[k]   = r_c[k-1];
      w_src_a[k]   = r_a[k-1];
      w_src_b[k]   = r_b[k-1];
      w_src_tag[k] = r_tag[k-1];
    end
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_seg[k] = {1'b0, w_src_a[k][SEG*k +: SEG]}
               + {1'b0, w_src_b[k][SEG*k +: SEG]}
               + {{SEG{1'b0}}, w_src_c[k]};
      w_nxt_sum[k] = w_src_sum[k];
      w_nxt_sum[k][SEG*k +: SEG] = w_seg[k][SEG-1:0];
    end
    // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
    w_cmsb = w_src_a[LAST][WIDTH-1] ^ w_src_b[LAST][WIDTH-1] ^ w_seg[LAST][SEG-1];
  end

  assign w_advance = out_ready | ~r_vld[LAST];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k] <= 1'b0;
        r_sum[k] <= '0;
        r_c[k]   <= 1'b0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_tag[k] <= '0;
      end
      r_cmsb <= 1'b0;
    end else if (w_advance) begin
      // Whole pipe shifts as one; a bubble enters stage 0 when in_valid=0.
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k] <= w_src_vld[k];
        r_sum[k] <= w_nxt_sum[k];
        r_c[k]   <= w_seg[k][SEG];
        r_a[k]   <= w_src_a[k];
        r_b[k]   <= w_src_b[k];
        r_tag[k] <= w_src_tag[k];
      end
      r_cmsb <= w_cmsb;
    end
  end

  assign in_ready  = w_advance;
  assign out_valid = r_vld[LAST];
  assign out_sum   = r_sum[LAST];
  assign out_cout  = r_c[LAST];
  assign out_ovf   = r_cmsb ^ r_c[LAST];
  assign out_tag   = r_tag[LAST];

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: three instances (STAGES=4, 1, 8; WIDTH=8) share one
// input stream and out_ready; each has its own in-order reference queue checked every cycle.
// Directed vectors, a stall stream, a reset flush and a long random run drive them.
module tb_pipelined_addsub;

  localparam int W  = 8;
  localparam int TW = 4;
  localparam int NI = 3;
  localparam int QD = 16;

  typedef struct packed {
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;
    logic [TW-1:0] tag;
  } exp_t;

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          sub;
    logic [TW-1:0] tag;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;
  } vec_t;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_cin;
  logic          in_sub;
  logic [TW-1:0] in_tag;
  logic          out_ready;

  logic          in_rdy [NI];
  logic          o_vld  [NI];
  logic [W-1:0]  o_sum  [NI];
  logic          o_cout [NI];
  logic          o_ovf  [NI];
  logic [TW-1:0] o_tag  [NI];

  pipelined_addsub #(.WIDTH(W), .STAGES(4), .TAG_W(TW)) u_s4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[0]),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub), .in_tag(in_tag),
    .out_valid(o_vld[0]), .out_ready(out_ready), .out_sum(o_sum[0]),
    .out_cout(o_cout[0]), .out_ovf(o_ovf[0]), .out_tag(o_tag[0]));

  pipelined_addsub #(.WIDTH(W), .STAGES(1), .TAG_W(TW)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[1]),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub), .in_tag(in_tag),
    .out_valid(o_vld[1]), .out_ready(out_ready), .out_sum(o_sum[1]),
    .out_cout(o_cout[1]), .out_ovf(o_ovf[1]), .out_tag(o_tag[1]));

  pipelined_addsub #(.WIDTH(W), .STAGES(8), .TAG_W(TW)) u_s8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[2]),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub), .in_tag(in_tag),
    .out_valid(o_vld[2]), .out_ready(out_ready), .out_sum(o_sum[2]),
    .out_cout(o_cout[2]), .out_ovf(o_ovf[2]), .out_tag(o_tag[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // Reference queues, one per instance.
  exp_t q     [NI][QD];
  int   q_hd  [NI];
  int   q_cnt [NI];
  int   pushes[NI];
  logic hold  [NI];
  logic [W+TW+2:0] prev [NI];
  bit   armed;
  bit   acc0;
  int   got_total;
  logic [TW-1:0] got_tag [64];

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Plain integer arithmetic: A+B+c or A-B-c, carry = unsigned wrap/no-borrow,
  // overflow = signed result outside [-128,127].
  function automatic exp_t ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic cin, input logic sub, input logic [TW-1:0] tag);
    exp_t e;
    int ua, ub, c, sa, sb, r, sr;
    ua = int'(a);
    ub = int'(b);
    c  = cin ? 1 : 0;
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    if (sub) begin
      r  = ua - ub - c;
      sr = sa - sb - c;
      e.cout = (r >= 0);
    end else begin
      r  = ua + ub + c;
      sr = sa + sb + c;
      e.cout = (r > 255);
    end
    e.sum = 8'(r & 255);
    e.ovf = (sr > 127) || (sr < -128);
    e.tag = tag;
    return e;
  endfunction

  // Runs at the negedge, seeing exactly what the next posedge will act on.
  task automatic monitor();
    exp_t e;
    logic [W+TW+2:0] cur;
    acc0 = in_valid && in_rdy[0];
    if (rst) begin
      for (int i = 0; i < NI; i++) begin
        q_hd[i]  = 0;
        q_cnt[i] = 0;
        hold[i]  = 1'b0;
      end
      armed = 1'b1;
      return;
    end
    if (!armed) return;
    for (int i = 0; i < NI; i++) begin
      cur = {o_vld[i], o_sum[i], o_cout[i], o_ovf[i], o_tag[i]};
      chk(in_rdy[i] == (!o_vld[i] || out_ready), "in_ready_rule", int'(in_rdy[i]),
          int'(!o_vld[i] || out_ready));
      if (hold[i])
        chk(cur == prev[i], "stall_stable", int'(cur), int'(prev[i]));
      if (o_vld[i] && out_ready) begin
        if (q_cnt[i] == 0) begin
          chk(1'b0, "unexpected_result", int'(o_tag[i]), 0);
        end else begin
          e = q[i][q_hd[i]];
          chk({o_sum[i], o_cout[i], o_ovf[i], o_tag[i]} == e, "result_vs_model",
              int'({o_sum[i], o_cout[i], o_ovf[i], o_tag[i]}), int'(e));
          q_hd[i]  = (q_hd[i] + 1) % QD;
          q_cnt[i] = q_cnt[i] - 1;
        end
        if (i == 0) begin
          got_tag[got_total % 64] = o_tag[0];
          got_total++;
        end
      end
      if (in_valid && in_rdy[i]) begin
        if (q_cnt[i] >= QD) begin
          chk(1'b0, "model_overflow", q_cnt[i], QD - 1);
        end else begin
          q[i][(q_hd[i] + q_cnt[i]) % QD] = ref_model(in_a, in_b, in_cin, in_sub, in_tag);
          q_cnt[i]  = q_cnt[i] + 1;
          pushes[i] = pushes[i] + 1;
        end
      end
      hold[i] = o_vld[i] && !out_ready;
      prev[i] = cur;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a = v.a; in_b = v.b; in_cin = v.cin; in_sub = v.sub; in_tag = v.tag;
    step();
    chk(acc0, "vec_accept", int'(acc0), 1);
    in_valid = 1'b0;
    lat = 0;
    while (!o_vld[0] && lat < 20) begin
      step();
      lat++;
    end
    chk(lat == 3, "vec_latency", lat, 3);
    chk(o_sum[0] == v.sum, "vec_sum", int'(o_sum[0]), int'(v.sum));
    chk(o_cout[0] == v.cout, "vec_cout", int'(o_cout[0]), int'(v.cout));
    chk(o_ovf[0] == v.ovf, "vec_ovf", int'(o_ovf[0]), int'(v.ovf));
    chk(o_tag[0] == v.tag, "vec_tag", int'(o_tag[0]), int'(v.tag));
    step();
  endtask

  vec_t tbl [7];
  bit   pat [4];

  initial begin
    int sent, cyc, base, seen;
    vec_t v;
    total = 0; bad = 0; armed = 1'b0; acc0 = 1'b0; got_total = 0;
    for (int i = 0; i < NI; i++) begin
      q_hd[i] = 0; q_cnt[i] = 0; pushes[i] = 0; hold[i] = 1'b0; prev[i] = '0;
    end

    //            a      b      cin   sub   tag   sum    cout  ovf
    tbl[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 4'd3, 8'h00, 1'b1, 1'b0};
    tbl[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 4'd4, 8'h80, 1'b0, 1'b1};
    tbl[2] = '{8'h80, 8'h80, 1'b0, 1'b0, 4'd5, 8'h00, 1'b1, 1'b1};
    tbl[3] = '{8'h0F, 8'h00, 1'b1, 1'b0, 4'd6, 8'h10, 1'b0, 1'b0};
    tbl[4] = '{8'h05, 8'h07, 1'b0, 1'b1, 4'd7, 8'hFE, 1'b0, 1'b0};
    tbl[5] = '{8'h80, 8'h01, 1'b0, 1'b1, 4'd8, 8'h7F, 1'b1, 1'b1};
    tbl[6] = '{8'h10, 8'h0F, 1'b1, 1'b1, 4'd9, 8'h00, 1'b1, 1'b0};
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; in_tag = '0;
    repeat (3) step();
    rst = 1'b0;

    // Reset state, with out_ready low so in_ready=1 comes from the empty pipe.
    chk(o_vld[0] == 1'b0, "rst_out_valid", int'(o_vld[0]), 0);
    chk(o_sum[0] == 8'h00, "rst_out_sum", int'(o_sum[0]), 0);
    chk(o_cout[0] == 1'b0, "rst_out_cout", int'(o_cout[0]), 0);
    chk(o_ovf[0] == 1'b0, "rst_out_ovf", int'(o_ovf[0]), 0);
    chk(o_tag[0] == 4'h0, "rst_out_tag", int'(o_tag[0]), 0);
    chk(in_rdy[0] == 1'b1, "rst_in_ready", int'(in_rdy[0]), 1);

    for (int t = 0; t < 7; t++) begin
      v = tbl[t];
      run_vec(v);
    end
    repeat (10) step();

    // Back-to-back stream with out_ready pattern 1,0,0,1.
    base = got_total;
    sent = 0;
    cyc  = 0;
    while ((sent < 8 || got_total - base < 8) && cyc < 200) begin
      out_ready = pat[cyc % 4];
      in_valid  = (sent < 8);
      in_a   = 8'($urandom);
      in_b   = 8'($urandom);
      in_cin = 1'($urandom);
      in_sub = 1'($urandom);
      in_tag = 4'(sent);
      step();
      if (acc0) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    chk(got_total - base == 8, "stream_count", got_total - base, 8);
    for (int k = 0; k < 8; k++)
      chk(got_tag[(base + k) % 64] == 4'(k), "stream_order", int'(got_tag[(base + k) % 64]), k);
    out_ready = 1'b1;
    repeat (12) step();

    // Reset with three beats in flight: none of them may ever come out.
    for (int j = 0; j < 3; j++) begin
      in_valid = 1'b1;
      in_a = 8'(20 + j); in_b = 8'h03; in_cin = 1'b0; in_sub = 1'b0; in_tag = 4'(10 + j);
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk(o_vld[0] == 1'b0, "flush_out_valid", int'(o_vld[0]), 0);
    seen = 0;
    for (int j = 0; j < 10; j++) begin
      step();
      if (o_vld[0]) seen++;
    end
    chk(seen == 0, "flush_no_output", seen, 0);
    v = '{8'h3C, 8'h44, 1'b1, 1'b0, 4'd13, 8'h81, 1'b0, 1'b1};
    run_vec(v);

    // Random traffic on all three depths.
    for (int i = 0; i < NI; i++) pushes[i] = 0;
    for (int c = 0; c < 26000; c++) begin
      in_valid  = ($urandom % 4) != 0;
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      in_cin    = 1'($urandom);
      in_sub    = 1'($urandom);
      in_tag    = 4'($urandom);
      out_ready = ($urandom % 10) < 7;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) step();
    for (int i = 0; i < NI; i++) begin
      chk(pushes[i] >= 10000, "random_beats", pushes[i], 10000);
      chk(q_cnt[i] == 0, "random_drained", q_cnt[i], 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
